// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-side arbiter.
// fifo_data layout (LSB first): payload [DATA_WIDTH-1:0], last flag, source id.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Bit position of the last flag inside a pushed word.
    function automatic int unsigned last_bit(input int unsigned data_width);
        return data_width;
    endfunction

    // LSB of the source id field inside a pushed word.
    function automatic int unsigned id_lsb(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after rr_ptr,
// wrapping modulo NUM_REQ.
// Ports:
//   valid     in  NUM_REQ   request vector
//   rr_ptr    in  ID_WIDTH  highest-priority index this cycle
//   any_valid out 1         at least one request present
//   grant     out ID_WIDTH  chosen index (0 when any_valid=0)
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = ($clog2(NUM_REQ) > 0 ? $clog2(NUM_REQ) : 1)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                any_valid,
    output logic [ID_WIDTH-1:0] grant
);

    int unsigned idx;

    // Scan offsets in priority order; wrap explicitly so non-power-of-two sizes work.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && valid[ID_WIDTH'(idx)]) begin
                any_valid = 1'b1;
                grant     = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares the push side of one FIFO between NUM_REQ valid/ready producers.
// Round-robin between packets; a producer keeps the FIFO from its first beat
// until its last beat is pushed. Handshake is combinational, only the
// arbitration state is registered.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      in  NUM_REQ             per-producer beat valid
//   req_last       in  NUM_REQ             per-producer last beat of packet
//   req_data       in  NUM_REQ*DATA_WIDTH  producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      out NUM_REQ             beat accepted this cycle
//   fifo_push      out 1                   push strobe
//   fifo_data      out OUT_WIDTH           {src_id, last, payload}, 0 when not pushing
//   fifo_in_ready  in  1                   FIFO not full
//   owner_id       out ID_WIDTH            locked producer, 0 when idle
//   locked         out 1                   packet in progress
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = ($clog2(NUM_REQ) > 0 ? $clog2(NUM_REQ) : 1),
    parameter int unsigned OUT_WIDTH  = ID_WIDTH + 1 + DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_push,
    output logic [OUT_WIDTH-1:0]          fifo_data,
    input  logic                          fifo_in_ready,
    output logic [ID_WIDTH-1:0]           owner_id,
    output logic                          locked
);

    localparam int unsigned          LAST_BIT = last_bit(DATA_WIDTH);
    localparam int unsigned          ID_LSB   = id_lsb(DATA_WIDTH);
    localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

    arb_state_t            state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   owner, owner_nxt;
    logic [ID_WIDTH-1:0]   cand, sel_id;
    logic                  any_valid, sel_valid, sel_last, accept;
    logic [DATA_WIDTH-1:0] sel_data;

    // Explicit wrap so NUM_REQ-1 + 1 returns to 0 for any NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] ptr_inc(input logic [ID_WIDTH-1:0] p);
        return (p == LAST_ID) ? '0 : p + ID_WIDTH'(1);
    endfunction

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .grant     (cand)
    );

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Source select, handshake outputs and next-state.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        req_ready  = '0;
        fifo_push  = 1'b0;
        fifo_data  = '0;
        owner_id   = '0;
        locked     = 1'b0;
        sel_id     = cand;
        sel_valid  = any_valid;
        sel_last   = 1'b0;
        sel_data   = '0;

        if (state == ARB_LOCKED) begin
            sel_id    = owner;
            sel_valid = req_valid[owner];
        end

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == sel_id) begin
                sel_last = req_last[i];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        accept = sel_valid && fifo_in_ready && !rst;

        // Owner sees ready even while idle between beats; nobody else does.
        if (!rst) begin
            if (state == ARB_LOCKED) begin
                locked   = 1'b1;
                owner_id = owner;
            end
            if (state == ARB_LOCKED || any_valid) begin
                req_ready[sel_id] = fifo_in_ready;
            end
        end

        fifo_push = accept;
        if (accept) begin
            fifo_data[DATA_WIDTH-1:0]        = sel_data;
            fifo_data[LAST_BIT]              = sel_last;
            fifo_data[ID_LSB +: ID_WIDTH]    = sel_id;
        end

        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        rr_ptr_nxt = ptr_inc(cand);
                    end else begin
                        owner_nxt = cand;
                        state_nxt = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (accept && sel_last) begin
                    state_nxt  = ARB_IDLE;
                    rr_ptr_nxt = ptr_inc(owner);
                    owner_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed 4-port scenarios plus a random
// 3-port run, both checked against scoreboards of expected FIFO words.
module tb_fifo_push_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // 4-port instance
    logic [3:0]   v4, l4, ready4;
    logic [127:0] d4;
    logic         push4, ir4, lock4;
    logic [34:0]  data4;
    logic [1:0]   own4;

    // 3-port instance
    logic [2:0]   v3, l3, ready3;
    logic [95:0]  d3;
    logic         push3, ir3, lock3;
    logic [34:0]  data3;
    logic [1:0]   own3;

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(v4), .req_last(l4), .req_data(d4),
        .req_ready(ready4), .fifo_push(push4), .fifo_data(data4),
        .fifo_in_ready(ir4), .owner_id(own4), .locked(lock4)
    );

    fifo_push_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_last(l3), .req_data(d3),
        .req_ready(ready3), .fifo_push(push3), .fifo_data(data3),
        .fifo_in_ready(ir3), .owner_id(own3), .locked(lock3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- 4-port producers and scoreboard ----------------
    logic [32:0] pq[4][$];
    logic [34:0] exp_q[$];
    logic [3:0]  acc4 = '0;
    logic [3:0]  en4 = '1;
    logic        rst_nxt = 1'b1;
    logic        ir_nxt = 1'b1;

    function automatic logic [34:0] w4(input int id, input logic last, input logic [31:0] d);
        return {2'(id), last, d};
    endfunction

    task automatic load(input int port, input logic last, input logic [31:0] d);
        pq[port].push_back({last, d});
        exp_q.push_back(w4(port, last, d));
    endtask

    task automatic drive4();
        logic [32:0] b;
        for (int i = 0; i < 4; i++) begin
            if (en4[i] && pq[i].size() > 0) begin
                b = pq[i][0];
                v4[i] = 1'b1;
                l4[i] = b[32];
                d4[i*32 +: 32] = b[31:0];
            end else begin
                v4[i] = 1'b0;
                l4[i] = 1'b0;
                d4[i*32 +: 32] = '0;
            end
        end
    endtask

    task automatic mon4();
        if (push4) begin
            if (exp_q.size() == 0) check("unexpected_push", 64'(push4), 64'(0));
            else                   check("fifo_data", 64'(data4), 64'(exp_q.pop_front()));
        end
        acc4 = ready4 & v4;
    endtask

    task automatic cyc4();
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (acc4[i]) void'(pq[i].pop_front());
        #1;
        rst = rst_nxt;
        ir4 = ir_nxt;
        drive4();
        @(negedge clk);
        mon4();
    endtask

    // Expected per-cycle values for the directed phases.
    int t1_r[5]  = '{1, 2, 4, 8, 1};
    int t2_r[5]  = '{4, 4, 4, 8, 1};
    int t2_lk[5] = '{0, 1, 1, 0, 0};
    int t3_ir[7] = '{1, 0, 0, 1, 1, 1, 1};
    int t3_en[7] = '{1, 1, 1, 0, 1, 1, 1};
    int t3_p[7]  = '{1, 0, 0, 0, 1, 1, 1};
    int t3_r[7]  = '{2, 0, 0, 2, 2, 2, 1};
    int t3_lk[7] = '{0, 1, 1, 1, 1, 1, 0};

    // ---------------- 3-port random model ----------------
    logic [2:0]  acc3 = '0, pv3 = '0, pacc3 = '0, have3 = '0, inpkt3 = '0;
    int          rem3[3];
    int          seq3[3];
    int          wait3[3];
    logic [34:0] sb3[3][$];
    int          cur_src = 0;
    logic        in_stream = 1'b0;
    int          pushes = 0;

    task automatic mon3();
        int src;
        check("r_hold", 64'(pv3 & ~pacc3 & ~v3), 64'(0));
        check("r_onehot", 64'($countones(ready3) <= 1), 64'(1));
        check("r_push", 64'(push3), 64'(|(ready3 & v3)));
        if (push3) begin
            src = int'(data3[34:33]);
            check("r_src_range", 64'(src < 3), 64'(1));
            if (src < 3) begin
                check("r_src_grant", 64'(ready3 & v3), 64'(1 << src));
                if (sb3[src].size() == 0) check("r_unexpected", 64'(sb3[src].size()), 64'(1));
                else                      check("r_data", 64'(data3), 64'(sb3[src].pop_front()));
                if (in_stream) check("r_interleave", 64'(src), 64'(cur_src));
                cur_src   = src;
                in_stream = !data3[32];
                check("r_fair", 64'(wait3[src] <= 3), 64'(1));
                wait3[src] = 0;
                if (data3[32]) begin
                    for (int j = 0; j < 3; j++) if (j != src && v3[j]) wait3[j]++;
                end
            end
            pushes++;
        end
        pv3   = v3;
        pacc3 = ready3 & v3;
        acc3  = pacc3;
    endtask

    initial begin
        v4 = '0; l4 = '0; d4 = '0; ir4 = 1'b1;
        v3 = '0; l3 = '0; d3 = '0; ir3 = 1'b1;
        for (int i = 0; i < 3; i++) begin rem3[i] = 0; seq3[i] = 0; wait3[i] = 0; end

        // Reset with every producer already valid.
        load(0, 1'b1, 32'h10); load(1, 1'b1, 32'h20); load(2, 1'b1, 32'h30);
        load(3, 1'b1, 32'h40); load(0, 1'b1, 32'h11);
        drive4();
        @(negedge clk);
        mon4();
        check("rst_ready", 64'(ready4), 64'(0));
        check("rst_push", 64'(push4), 64'(0));
        check("rst_locked", 64'(lock4), 64'(0));
        check("rst_owner", 64'(own4), 64'(0));
        check("rst_data", 64'(data4), 64'(0));
        rst_nxt = 1'b0;

        // Single-beat round robin 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            cyc4();
            check("t1_push", 64'(push4), 64'(1));
            check("t1_ready", 64'(ready4), 64'(t1_r[k]));
            check("t1_last", 64'(data4[32]), 64'(1));
        end

        // Producer 2 locks a 3-beat packet while 0 and 3 wait.
        load(2, 1'b0, 32'hA0); load(2, 1'b0, 32'hA1); load(2, 1'b1, 32'hA2);
        pq[3].push_back({1'b1, 32'h60}); pq[0].push_back({1'b1, 32'h50});
        exp_q.push_back(w4(3, 1'b1, 32'h60)); exp_q.push_back(w4(0, 1'b1, 32'h50));
        for (int k = 0; k < 5; k++) begin
            cyc4();
            check("t2_ready", 64'(ready4), 64'(t2_r[k]));
            check("t2_locked", 64'(lock4), 64'(t2_lk[k]));
            check("t2_owner", 64'(own4), 64'(t2_lk[k] != 0 ? 2 : 0));
        end

        // FIFO full and owner gap in the middle of a locked packet.
        load(1, 1'b0, 32'hB0); load(1, 1'b0, 32'hB1); load(1, 1'b1, 32'hB2);
        load(0, 1'b1, 32'h70);
        for (int k = 0; k < 7; k++) begin
            ir_nxt = t3_ir[k] != 0;
            en4[1] = t3_en[k] != 0;
            cyc4();
            check("t3_push", 64'(push4), 64'(t3_p[k]));
            check("t3_ready", 64'(ready4), 64'(t3_r[k]));
            check("t3_locked", 64'(lock4), 64'(t3_lk[k]));
        end

        // Pointer wrap: grant 2, then 3 alone, then 0 ahead of 1.
        load(2, 1'b1, 32'h80);
        cyc4(); check("t4_ready2", 64'(ready4), 64'(4));
        load(3, 1'b1, 32'h90);
        cyc4(); check("t4_ready3", 64'(ready4), 64'(8));
        load(0, 1'b1, 32'h0A); load(1, 1'b1, 32'h0B);
        cyc4(); check("t4_wrap0", 64'(ready4), 64'(1));
        cyc4(); check("t4_then1", 64'(ready4), 64'(2));

        // Reset mid-packet with owner 1; rr_ptr was 2 beforehand.
        pq[1].push_back({1'b0, 32'hC0}); pq[1].push_back({1'b0, 32'hC1});
        pq[1].push_back({1'b1, 32'hC2});
        exp_q.push_back(w4(1, 1'b0, 32'hC0)); exp_q.push_back(w4(1, 1'b0, 32'hC1));
        cyc4(); check("t5_first", 64'(ready4), 64'(2));
        load(0, 1'b1, 32'hD0); load(2, 1'b1, 32'hE0);
        cyc4();
        check("t5_locked", 64'(lock4), 64'(1));
        check("t5_owner", 64'(own4), 64'(1));
        check("t5_ready", 64'(ready4), 64'(2));
        rst_nxt = 1'b1;
        cyc4();
        check("t5_rst_ready", 64'(ready4), 64'(0));
        check("t5_rst_push", 64'(push4), 64'(0));
        check("t5_rst_locked", 64'(lock4), 64'(0));
        pq[1].delete();
        rst_nxt = 1'b0;
        cyc4();
        check("t5_after_ready", 64'(ready4), 64'(1));
        check("t5_after_locked", 64'(lock4), 64'(0));
        cyc4();
        check("t5_next", 64'(ready4), 64'(4));
        check("t_drained", 64'(exp_q.size()), 64'(0));

        // Random 3-port traffic.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc3[i]) begin
                    have3[i] = 1'b0;
                    rem3[i]--;
                    if (rem3[i] == 0) inpkt3[i] = 1'b0;
                end
                if (!have3[i]) begin
                    if (!inpkt3[i] && $urandom_range(0, 3) == 0) begin
                        inpkt3[i] = 1'b1;
                        rem3[i]   = int'($urandom_range(1, 4));
                    end
                    if (inpkt3[i] && $urandom_range(0, 3) != 0) begin
                        have3[i] = 1'b1;
                        l3[i] = (rem3[i] == 1);
                        d3[i*32 +: 32] = {8'(i), 24'(seq3[i])};
                        seq3[i]++;
                        sb3[i].push_back({2'(i), l3[i], d3[i*32 +: 32]});
                    end
                end
                v3[i] = have3[i];
            end
            ir3 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            mon3();
        end
        check("r_activity", 64'(pushes > 1000), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
